// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR : encoding inserted into IF/ID on bubbles and flushes (addi x0,x0,0)
//   if_state_e: fetch-stage mode (BOOT after reset, LOAD for program load, RUN)
//   PC_INCR   : byte increment between consecutive instructions
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } if_state_e;

  // Even parity of an instruction word, available to integrity checkers.
  function automatic logic word_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage and its surroundings.
//   load_en/load_we/load_addr/load_data : program-load port
//   stall/branch_taken/branch_target    : pipeline control from later stages
//   PC_out/instruction/fetch_valid      : IF/ID pipeline register toward decode
//   pc                                  : live fetch PC for debug
// master: the side driving control and load (pipeline/loader/testbench)
// slave : the fetch stage itself
interface instr_fetch_if #(parameter int PC_SIZE = 10);

  logic                 load_en;
  logic                 load_we;
  logic [PC_SIZE-3:0]   load_addr;
  logic [31:0]          load_data;
  logic                 stall;
  logic                 branch_taken;
  logic [PC_SIZE-1:0]   branch_target;
  logic [PC_SIZE-1:0]   PC_out;
  logic [31:0]          instruction;
  logic                 fetch_valid;
  logic [PC_SIZE-1:0]   pc;

  modport master (
    output load_en, load_we, load_addr, load_data,
    output stall, branch_taken, branch_target,
    input  PC_out, instruction, fetch_valid, pc
  );

  modport slave (
    input  load_en, load_we, load_addr, load_data,
    input  stall, branch_taken, branch_target,
    output PC_out, instruction, fetch_valid, pc
  );

endinterface

// File: rtl/instr_fetch_imem.sv
// Instruction memory: word-addressed RAM, one synchronous write port and one
// combinational read port. Contents are deliberately not reset so a loaded
// program survives a core reset.
//   clock : write clock
//   we    : write strobe
//   waddr : word write address
//   wdata : word to write
//   raddr : word read address
//   rdata : word at raddr (combinational)
module imem #(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_r [0:DEPTH-1];

  // Synchronous write port; a write is visible to reads after this edge.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, BOOT/LOAD/RUN mode FSM, instruction
// memory and the IF/ID pipeline register feeding decode.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : load port, stall/branch control, IF/ID outputs and debug pc
module instr_fetch
  import if_pkg::*;
#(
  parameter int PC_SIZE = 10
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  localparam int AW = PC_SIZE - 2;

  if_state_e            state_r;
  logic [PC_SIZE-1:0]   pc_r;
  logic [PC_SIZE-1:0]   pc_out_r;
  logic [31:0]          instr_r;
  logic                 valid_r;

  logic                 mem_we_s;
  logic [31:0]          fetch_word_s;
  logic [PC_SIZE-1:0]   pc_next_s;
  logic [PC_SIZE-1:0]   target_s;

  // Writes are only accepted while loading; in RUN the strobe is ignored.
  assign mem_we_s  = (state_r == LOAD) && bus.load_we;
  // Natural wrap modulo 2^PC_SIZE comes from the fixed register width.
  assign pc_next_s = pc_r + PC_SIZE'(PC_INCR);
  // Branch targets are forced word-aligned.
  assign target_s  = bus.branch_target & {{(PC_SIZE-2){1'b1}}, 2'b00};

  imem #(.AW(AW)) u_imem (
    .clock (clock),
    .we    (mem_we_s),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_r[PC_SIZE-1:2]),
    .rdata (fetch_word_s)
  );

  // Mode FSM together with the PC and IF/ID register updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= BOOT;
      pc_r     <= {PC_SIZE{1'b0}};
      pc_out_r <= {PC_SIZE{1'b0}};
      instr_r  <= NOP_INSTR;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= bus.load_en ? LOAD : RUN;
          pc_r    <= {PC_SIZE{1'b0}};
        end
        LOAD: begin
          state_r  <= bus.load_en ? LOAD : RUN;
          pc_r     <= {PC_SIZE{1'b0}};
          pc_out_r <= {PC_SIZE{1'b0}};
          instr_r  <= NOP_INSTR;
          valid_r  <= 1'b0;
        end
        RUN: begin
          state_r <= bus.load_en ? LOAD : RUN;
          if (bus.branch_taken) begin
            // Flush the wrong-path fetch; PC_out keeps the squashed slot's address.
            pc_r     <= target_s;
            pc_out_r <= pc_r;
            instr_r  <= NOP_INSTR;
            valid_r  <= 1'b0;
          end else if (bus.stall) begin
            pc_r     <= pc_r;
            pc_out_r <= pc_out_r;
            instr_r  <= instr_r;
            valid_r  <= valid_r;
          end else begin
            pc_r     <= pc_next_s;
            pc_out_r <= pc_r;
            instr_r  <= fetch_word_s;
            valid_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= BOOT;
          pc_r     <= {PC_SIZE{1'b0}};
          pc_out_r <= {PC_SIZE{1'b0}};
          instr_r  <= NOP_INSTR;
          valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_r;
  assign bus.PC_out      = pc_out_r;
  assign bus.instruction = instr_r;
  assign bus.fetch_valid = valid_r;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int PC_SIZE = 10;
  localparam int WORDS   = 1 << (PC_SIZE - 2);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int unsigned pc;
    int unsigned pc_out;
    logic [31:0] ins;
    logic        valid;
  } snap_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  instr_fetch_if #(.PC_SIZE(PC_SIZE)) bus ();

  instr_fetch #(.PC_SIZE(PC_SIZE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  snap_t exp_q[$];

  // Reference model state: mode 0=boot 1=load 2=run
  int unsigned m_mode;
  int unsigned m_pc;
  int unsigned m_pc_out;
  logic [31:0] m_ins;
  logic        m_valid;
  logic [31:0] m_mem [WORDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_pc_out = 0; m_ins = NOP; m_valid = 1'b0;
  endtask

  // One rising edge of the reference: inputs as presented at that edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = bus.load_en ? 1 : 2;
    end else if (m_mode == 1) begin
      if (bus.load_we) m_mem[bus.load_addr] = bus.load_data;
      m_pc = 0; m_pc_out = 0; m_ins = NOP; m_valid = 1'b0;
      if (!bus.load_en) m_mode = 2;
    end else begin
      if (bus.branch_taken) begin
        m_pc_out = m_pc;
        m_pc = (int'(bus.branch_target) / 4) * 4;
        m_ins = NOP; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_pc_out = m_pc;
        m_ins = m_mem[m_pc / 4];
        m_valid = 1'b1;
        m_pc = (m_pc + 4) % (1 << PC_SIZE);
      end
      if (bus.load_en) m_mode = 1;
    end
  endtask

  // Advance one clock: model follows the edge, expectation goes to the scoreboard.
  task automatic cycle();
    snap_t s;
    @(posedge clock);
    model_edge();
    s.pc = m_pc; s.pc_out = m_pc_out; s.ins = m_ins; s.valid = m_valid;
    exp_q.push_back(s);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.load_en = 1'b0; bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
  endtask

  task automatic direct_reset_check(input string tag);
    check({tag, "_pc"}, 32'(bus.pc), 32'd0);
    check({tag, "_pc_out"}, 32'(bus.PC_out), 32'd0);
    check({tag, "_instr"}, bus.instruction, NOP);
    check({tag, "_valid"}, 32'(bus.fetch_valid), 32'd0);
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation.
  initial begin
    snap_t s;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("sb_pc", 32'(bus.pc), s.pc);
        check("sb_valid", 32'(bus.fetch_valid), 32'(s.valid));
        check("sb_instr", bus.instruction, s.ins);
        if (s.valid) check("sb_pc_out", 32'(bus.PC_out), s.pc_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int load_cnt;
    idle_inputs();
    for (int i = 0; i < WORDS; i++) m_mem[i] = $urandom;
    m_mem[0] = 32'h0050_0093;
    m_mem[1] = 32'h00A0_0113;
    model_reset();
    #2 reset = 1'b1;
    #2 direct_reset_check("por");

    // Release into LOAD and fill the whole memory.
    @(negedge clock);
    reset = 1'b0;
    bus.load_en = 1'b1;
    cycle();
    for (int i = 0; i < WORDS; i++) begin
      bus.load_we = 1'b1; bus.load_addr = 8'(i); bus.load_data = m_mem[i];
      cycle();
      check("load_valid", 32'(bus.fetch_valid), 32'd0);
    end
    bus.load_we = 1'b0;
    bus.load_en = 1'b0;
    cycle();                              // LOAD -> RUN, pc=0
    cycle();
    check("run0_pc_out", 32'(bus.PC_out), 32'd0);
    check("run0_instr", bus.instruction, 32'h0050_0093);
    cycle();
    check("run1_pc_out", 32'(bus.PC_out), 32'd4);
    check("run1_instr", bus.instruction, 32'h00A0_0113);
    cycle();                              // PC_out=8, pc=12

    // Stall three cycles with PC_out=8.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc_out", 32'(bus.PC_out), 32'd8);
      check("stall_pc", 32'(bus.pc), 32'd12);
    end
    bus.stall = 1'b0;
    cycle();
    check("unstall_pc_out", 32'(bus.PC_out), 32'd12);

    // Branch together with stall at pc=16.
    bus.branch_taken = 1'b1; bus.stall = 1'b1; bus.branch_target = 10'h02F;
    cycle();
    check("br_pc", 32'(bus.pc), 32'h2C);
    check("br_valid", 32'(bus.fetch_valid), 32'd0);
    check("br_instr", bus.instruction, NOP);
    idle_inputs();
    cycle();
    check("br_tgt_pc_out", 32'(bus.PC_out), 32'h2C);
    check("br_tgt_instr", bus.instruction, m_mem[11]);

    // Write strobe in RUN must be ignored.
    bus.load_we = 1'b1; bus.load_addr = '0; bus.load_data = 32'hFFFF_FFFF;
    cycle();
    idle_inputs();
    bus.branch_taken = 1'b1; bus.branch_target = '0;
    cycle();
    idle_inputs();
    cycle();
    check("we_ignored", bus.instruction, 32'h0050_0093);

    // Wrap-around at the top of the address space.
    bus.branch_taken = 1'b1; bus.branch_target = 10'd1016;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    check("wrap_top", 32'(bus.PC_out), 32'd1020);
    cycle();
    check("wrap_zero", 32'(bus.PC_out), 32'd0);

    // Randomized mix of stalls, branches, stray writes and reload bursts.
    load_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      if (load_cnt == 0 && $urandom_range(0, 99) < 3) load_cnt = $urandom_range(2, 6);
      if (load_cnt > 0) begin
        bus.load_en = 1'b1;
        load_cnt--;
      end
      bus.load_we       = ($urandom_range(0, 1) == 1);
      bus.load_addr     = 8'($urandom);
      bus.load_data     = $urandom;
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 9) == 0);
      bus.branch_target = 10'($urandom);
      cycle();
    end

    // Asynchronous reset between edges, then boot straight into RUN.
    idle_inputs();
    #2 reset = 1'b1;
    #1 model_reset();
    direct_reset_check("mid");
    cycle();
    reset = 1'b0;
    cycle();                              // BOOT -> RUN
    check("boot_not_yet", 32'(bus.fetch_valid), 32'd0);
    cycle();
    check("boot_valid", 32'(bus.fetch_valid), 32'd1);
    check("boot_pc_out", 32'(bus.PC_out), 32'd0);
    check("boot_instr", bus.instruction, m_mem[0]);
    for (int n = 0; n < 5; n++) cycle();

    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
